// File: rtl/dma_channel_arbiter_pkg.sv
// Shared types and constants for the DMA channel arbiter and its helpers.
package dma_pkg;
  localparam int DMA_DATA_W    = 32;
  localparam int DMA_ADDR_W    = 13;
  localparam int DMA_MAX_WORDS = 32;
  localparam int DMA_CNT_W     = 6;

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} dma_state_t;

  // Each device starts out owning its own MAX_WORDS-sized slice of memory.
  function automatic int base_reset(input int dev, input int max_words);
    return dev * max_words;
  endfunction
endpackage

// File: rtl/dma_channel_arbiter_if.sv
// Device, memory-write and CPU config signals of the DMA channel arbiter.
interface dma_channel_arbiter_if
  import dma_pkg::*;
#(
  parameter int N_DEV  = 2,
  parameter int DATA_W = DMA_DATA_W,
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int CNT_W  = DMA_CNT_W
);
  logic [N_DEV-1:0]  gpio_req;
  logic [N_DEV-1:0]  ack;
  logic              io_write;
  logic [DATA_W-1:0] dev_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cfg_we;
  logic [1:0]        cfg_dev;
  logic [ADDR_W-1:0] cfg_base;
  logic              cfg_err;
  logic              busy;
  logic              done;
  logic [1:0]        cur_dev;
  logic [CNT_W-1:0]  burst_len;

  modport slave (
    input  gpio_req, dev_data, cfg_we, cfg_dev, cfg_base,
    output ack, io_write, mem_we, mem_addr, mem_wdata, cfg_err, busy, done, cur_dev, burst_len
  );

  modport master (
    output gpio_req, dev_data, cfg_we, cfg_dev, cfg_base,
    input  ack, io_write, mem_we, mem_addr, mem_wdata, cfg_err, busy, done, cur_dev, burst_len
  );
endinterface

// File: rtl/dma_channel_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester after the
// last-granted index, scanning modulo N.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic [N-1:0] grant,
  output logic [1:0]   grant_idx,
  output logic         valid
);
  always_comb begin
    grant     = '0;
    grant_idx = last;
    valid     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid && req[i] && i == (int'(last) + k) % N) begin
          grant[i]  = 1'b1;
          grant_idx = 2'(i);
          valid     = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dma_channel_arbiter.sv
// Round-robin DMA channel: grants one IO device the shared databus and
// streams its words into memory at that device's base pointer.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int N_DEV     = 2,
  parameter int DATA_W    = DMA_DATA_W,
  parameter int ADDR_W    = DMA_ADDR_W,
  parameter int MAX_WORDS = DMA_MAX_WORDS,
  parameter int CNT_W     = DMA_CNT_W
) (
  input logic clk,
  input logic rst_n,
  dma_channel_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  dma_state_t        state;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] base [N_DEV];
  logic [ADDR_W-1:0] cur_base;
  logic [N_DEV-1:0]  ack_q;
  logic [1:0]        cur_dev_q;
  logic [N_DEV-1:0]  arb_grant;
  logic [1:0]        arb_idx;
  logic              arb_valid;
  logic              granted_req;
  logic              burst_end;
  logic              cfg_ok;

  rr_arbiter #(.N(N_DEV)) u_arb (
    .req       (bus.gpio_req),
    .last      (cur_dev_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  assign bus.ack     = ack_q;
  assign bus.cur_dev = cur_dev_q;

  // ack_q is one-hot on the granted device for the whole burst, so it doubles as the selector.
  assign granted_req = |(bus.gpio_req & ack_q);
  assign burst_end   = (state == XFER) && !(granted_req && count < MAX_CNT);
  assign cfg_ok      = bus.cfg_we && (int'(bus.cfg_dev) < N_DEV) &&
                       !((state != IDLE) && (bus.cfg_dev == cur_dev_q));

  always_comb begin
    cur_base = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (ack_q[i]) cur_base = base[i];
    end
  end

  // Base pointers: CPU writes and end-of-burst advance never hit the same entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.cfg_err <= 1'b0;
      for (int i = 0; i < N_DEV; i++) begin
        base[i] <= ADDR_W'(base_reset(i, MAX_WORDS));
      end
    end else begin
      bus.cfg_err <= bus.cfg_we && !cfg_ok;
      for (int i = 0; i < N_DEV; i++) begin
        if (cfg_ok && int'(bus.cfg_dev) == i) begin
          base[i] <= bus.cfg_base;
        end else if (burst_end && ack_q[i]) begin
          base[i] <= base[i] + ADDR_W'(count);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ack_q         <= '0;
      cur_dev_q     <= 2'(N_DEV - 1);
      count         <= '0;
      bus.io_write  <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.burst_len <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      bus.done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            state        <= GRANT;
            ack_q        <= arb_grant;
            cur_dev_q    <= arb_idx;
            count        <= '0;
            bus.io_write <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        GRANT: state <= XFER;
        XFER: begin
          if (!burst_end) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= cur_base + ADDR_W'(count);
            bus.mem_wdata <= bus.dev_data;
            count         <= count + CNT_W'(1);
          end else begin
            state         <= DONE;
            ack_q         <= '0;
            bus.io_write  <= 1'b1;
            bus.done      <= 1'b1;
            bus.burst_len <= count;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: directed bursts plus randomized traffic
// compared every cycle against a behavioural model of the channel.
module tb_dma_channel_arbiter;
  import dma_pkg::*;

  localparam int N_DEV    = 2;
  localparam int MAX_W    = 32;
  localparam int ADDR_MOD = 8192;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dma_channel_arbiter_if #(.N_DEV(N_DEV)) bus_if ();

  dma_channel_arbiter #(.N_DEV(N_DEV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: burst progress is tracked as edges elapsed since the grant.
  bit          model_valid = 1'b0;
  int          m_base [4];
  int          m_last, m_dev, m_age, m_words;
  bit          m_active, m_finishing;
  logic [1:0]  e_ack;
  bit          e_io_write, e_we, e_done, e_busy, e_cfg_err;
  logic [12:0] e_addr;
  logic [31:0] e_wdata;
  int          e_cur, e_len;

  logic [44:0] wlog [$];
  int          wr_cnt [4];
  int          done_cnt;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic model_step();
    bit cfg_ok;
    int upd_dev, upd_val;
    e_we      = 1'b0;
    e_done    = 1'b0;
    e_cfg_err = 1'b0;
    if (!rst_n) begin
      model_valid = 1'b1;
      for (int i = 0; i < 4; i++) m_base[i] = i * MAX_W;
      m_last      = N_DEV - 1;
      m_active    = 1'b0;
      m_finishing = 1'b0;
      e_ack       = '0;
      e_io_write  = 1'b1;
      e_busy      = 1'b0;
      e_len       = 0;
      e_cur       = N_DEV - 1;
    end else if (model_valid) begin
      cfg_ok = bus_if.cfg_we && int'(bus_if.cfg_dev) < N_DEV &&
               !(m_active && int'(bus_if.cfg_dev) == m_dev);
      e_cfg_err = bus_if.cfg_we && !cfg_ok;
      upd_dev = -1;
      upd_val = 0;
      if (m_finishing) begin
        m_finishing = 1'b0;
        m_active    = 1'b0;
        e_busy      = 1'b0;
      end else if (m_active) begin
        m_age++;
        if (m_age >= 2) begin
          if (bus_if.gpio_req[m_dev] && m_words < MAX_W) begin
            e_we    = 1'b1;
            e_addr  = 13'((m_base[m_dev] + m_words) % ADDR_MOD);
            e_wdata = bus_if.dev_data;
            m_words++;
          end else begin
            e_done      = 1'b1;
            e_len       = m_words;
            e_ack       = '0;
            e_io_write  = 1'b1;
            m_finishing = 1'b1;
            upd_dev     = m_dev;
            upd_val     = (m_base[m_dev] + m_words) % ADDR_MOD;
          end
        end
      end else begin
        for (int k = 1; k <= N_DEV; k++) begin
          int d;
          d = (m_last + k) % N_DEV;
          if (!m_active && bus_if.gpio_req[d]) begin
            m_active   = 1'b1;
            m_dev      = d;
            m_last     = d;
            m_age      = 0;
            m_words    = 0;
            e_ack      = 2'(1 << d);
            e_io_write = 1'b0;
            e_busy     = 1'b1;
            e_cur      = d;
          end
        end
      end
      if (upd_dev >= 0) m_base[upd_dev] = upd_val;
      if (cfg_ok) m_base[bus_if.cfg_dev] = int'(bus_if.cfg_base);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check_output("ack", bus_if.ack, e_ack);
      check_output("io_write", bus_if.io_write, e_io_write);
      check_output("mem_we", bus_if.mem_we, e_we);
      check_output("done", bus_if.done, e_done);
      check_output("busy", bus_if.busy, e_busy);
      check_output("cfg_err", bus_if.cfg_err, e_cfg_err);
      check_output("cur_dev", bus_if.cur_dev, e_cur);
      check_output("burst_len", bus_if.burst_len, e_len);
      if (e_we) begin
        check_output("mem_addr", bus_if.mem_addr, e_addr);
        check_output("mem_wdata", bus_if.mem_wdata, e_wdata);
      end
      if (bus_if.mem_we === 1'b1) begin
        wlog.push_back({bus_if.mem_addr, bus_if.mem_wdata});
        wr_cnt[bus_if.cur_dev]++;
      end
      if (bus_if.done === 1'b1) done_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] req, input bit we, input logic [1:0] dev,
                                input logic [12:0] base);
    bus_if.gpio_req = req;
    bus_if.cfg_we   = we;
    bus_if.cfg_dev  = dev;
    bus_if.cfg_base = base;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.gpio_req = '0;
    bus_if.cfg_we   = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_burst(input int dev, input int words);
    int target, guard;
    target = wr_cnt[dev] + words;
    bus_if.gpio_req[dev] = 1'b1;
    guard = 0;
    while (wr_cnt[dev] < target && guard < 100) begin
      bus_if.dev_data = $urandom;
      step();
      guard++;
    end
    if (guard >= 100) fail_timeout("burst words");
    bus_if.gpio_req[dev] = 1'b0;
    guard = 0;
    while (bus_if.busy !== 1'b0 && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) fail_timeout("burst end");
    step();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard, start, first_dev, tidx;
    bit dropped1;
    logic [12:0] exp_a [4];

    rst_n = 1'b0;
    bus_if.gpio_req = '0;
    bus_if.dev_data = '0;
    bus_if.cfg_we   = 1'b0;
    bus_if.cfg_dev  = '0;
    bus_if.cfg_base = '0;
    for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
    done_cnt = 0;
    step();
    step();
    rst_n = 1'b1;

    check_output("reset ack", bus_if.ack, 2'b00);
    check_output("reset io_write", bus_if.io_write, 1'b1);
    check_output("reset mem_we", bus_if.mem_we, 1'b0);
    check_output("reset mem_addr", bus_if.mem_addr, 13'h0);
    check_output("reset cur_dev", bus_if.cur_dev, 2'd1);
    check_output("reset burst_len", bus_if.burst_len, 6'd0);

    // Full 32-word burst from device 0 with a counting data pattern.
    $display("[TB] full burst from device 0");
    wlog.delete();
    bus_if.gpio_req = 2'b01;
    for (int c = 0; c < 35; c++) begin
      bus_if.dev_data = 32'(32'h100 + c - 2);
      step();
      if (c == 0) check_output("t1 ack latency", bus_if.ack, 2'b01);
      if (c == 1) check_output("t1 turnaround no write", bus_if.mem_we, 1'b0);
      if (c == 2) check_output("t1 first write", {bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata},
                               {1'b1, 13'h0, 32'h100});
    end
    check_output("t1 done", bus_if.done, 1'b1);
    check_output("t1 burst_len", bus_if.burst_len, 6'd32);
    bus_if.gpio_req = 2'b00;
    step();
    step();
    check_output("t1 write count", wlog.size(), 32);
    check_output("t1 last write", wlog[31], {13'd31, 32'h11F});
    check_output("t1 model base0", m_base[0], 32);

    // Both devices request together; device 0 stops after 3 words, device 1 after 5.
    $display("[TB] two requesters, round robin");
    do_reset();
    wlog.delete();
    for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
    first_dev = -1;
    dropped1  = 1'b0;
    bus_if.gpio_req = 2'b11;
    guard = 0;
    while (guard < 120) begin
      bus_if.dev_data = $urandom;
      step();
      guard++;
      if (first_dev < 0 && bus_if.ack !== 2'b00) first_dev = int'(bus_if.cur_dev);
      if (dropped1) begin
        check_output("t2 ack1 released", bus_if.ack, 2'b00);
        dropped1 = 1'b0;
      end
      if (wr_cnt[0] >= 3) bus_if.gpio_req[0] = 1'b0;
      if (wr_cnt[1] >= 5 && bus_if.gpio_req[1]) begin
        bus_if.gpio_req[1] = 1'b0;
        dropped1 = 1'b1;
      end
      if (bus_if.gpio_req == 2'b00 && !dropped1 && bus_if.busy === 1'b0) break;
    end
    if (guard >= 120) fail_timeout("t2 bursts");
    check_output("t2 first grant", first_dev, 0);
    check_output("t2 write count", wlog.size(), 8);
    check_output("t2 dev1 first addr", wlog[3][44:32], 13'd32);
    check_output("t2 dev1 last addr", wlog[7][44:32], 13'd36);
    check_output("t2 burst_len", bus_if.burst_len, 6'd5);
    check_output("t2 model base1", m_base[1], 37);
    wlog.delete();
    run_burst(1, 1);
    check_output("t2 dev1 resumes", wlog[0][44:32], 13'd37);

    // Base pointer near the top of memory wraps to address 0.
    $display("[TB] config write and address wrap");
    apply_stimulus(2'b00, 1'b1, 2'd0, 13'h1FFE);
    bus_if.cfg_we = 1'b0;
    check_output("t3 cfg accepted", bus_if.cfg_err, 1'b0);
    wlog.delete();
    run_burst(0, 4);
    exp_a[0] = 13'h1FFE;
    exp_a[1] = 13'h1FFF;
    exp_a[2] = 13'h0000;
    exp_a[3] = 13'h0001;
    for (int i = 0; i < 4; i++) check_output("t3 wrap addr", wlog[i][44:32], exp_a[i]);
    check_output("t3 model base0", m_base[0], 2);
    wlog.delete();
    run_burst(0, 1);
    check_output("t3 base0 after wrap", wlog[0][44:32], 13'd2);

    // Config writes that must be rejected.
    $display("[TB] rejected config writes");
    wlog.delete();
    start = wr_cnt[0];
    bus_if.gpio_req = 2'b01;
    guard = 0;
    while (wr_cnt[0] < start + 1 && guard < 20) begin step(); guard++; end
    if (guard >= 20) fail_timeout("t4 first word");
    apply_stimulus(2'b01, 1'b1, 2'd0, 13'h0555);
    bus_if.cfg_we = 1'b0;
    check_output("t4 cfg granted dev", bus_if.cfg_err, 1'b1);
    guard = 0;
    while (wr_cnt[0] < start + 3 && guard < 20) begin step(); guard++; end
    if (guard >= 20) fail_timeout("t4 words");
    bus_if.gpio_req = 2'b00;
    step();
    step();
    step();
    check_output("t4 write count", wlog.size(), 3);
    check_output("t4 base unchanged", wlog[2][44:32], 13'd5);
    apply_stimulus(2'b00, 1'b1, 2'd3, 13'h0123);
    bus_if.cfg_we = 1'b0;
    check_output("t4 cfg bad dev", bus_if.cfg_err, 1'b1);
    step();
    check_output("t4 cfg_err pulse", bus_if.cfg_err, 1'b0);

    // Request dropped during turnaround: empty burst, pointer untouched.
    $display("[TB] zero-length burst");
    tidx = wlog.size();
    apply_stimulus(2'b01, 1'b0, 2'd0, 13'h0);
    step();
    apply_stimulus(2'b00, 1'b0, 2'd0, 13'h0);
    check_output("t4 zero done", bus_if.done, 1'b1);
    check_output("t4 zero burst_len", bus_if.burst_len, 6'd0);
    step();
    step();
    check_output("t4 zero no write", wlog.size(), tidx);
    run_burst(0, 1);
    check_output("t4 pointer kept", wlog[tidx][44:32], 13'd6);

    // Reset in the middle of a device 1 burst.
    $display("[TB] reset during transfer");
    start = wr_cnt[1];
    bus_if.gpio_req = 2'b10;
    guard = 0;
    while (wr_cnt[1] < start + 3 && guard < 30) begin
      bus_if.dev_data = $urandom;
      step();
      guard++;
    end
    if (guard >= 30) fail_timeout("t5 words");
    rst_n = 1'b0;
    bus_if.gpio_req = 2'b00;
    step();
    check_output("t5 mem_we", bus_if.mem_we, 1'b0);
    check_output("t5 ack", bus_if.ack, 2'b00);
    check_output("t5 busy", bus_if.busy, 1'b0);
    check_output("t5 io_write", bus_if.io_write, 1'b1);
    check_output("t5 cur_dev", bus_if.cur_dev, 2'd1);
    check_output("t5 burst_len", bus_if.burst_len, 6'd0);
    rst_n = 1'b1;
    wlog.delete();
    run_burst(0, 1);
    run_burst(1, 1);
    check_output("t5 base0 restored", wlog[0][44:32], 13'd0);
    check_output("t5 base1 restored", wlog[1][44:32], 13'd32);

    // Randomized traffic, config writes and occasional resets.
    $display("[TB] randomized traffic");
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int bit_idx;
      if ($urandom_range(0, 7) == 0) begin
        bit_idx = $urandom_range(0, N_DEV - 1);
        bus_if.gpio_req[bit_idx] = ~bus_if.gpio_req[bit_idx];
      end
      bus_if.dev_data = $urandom;
      bus_if.cfg_we   = ($urandom_range(0, 11) == 0);
      bus_if.cfg_dev  = 2'($urandom_range(0, 3));
      bus_if.cfg_base = 13'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    bus_if.cfg_we = 1'b0;
    bus_if.gpio_req = 2'b00;
    for (int i = 0; i < 40; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
